// File: rtl/pb_soc_cmd_bridge.sv
// Byte-stream command bridge: parses 'W'/'R' commands from the UART receive path,
// issues single-cycle register-bus transactions and returns one response byte per command.
module pb_soc_cmd_bridge #(
    parameter logic [7:0]  CMD_WR         = 8'h57,
    parameter logic [7:0]  CMD_RD         = 8'h52,
    parameter logic [7:0]  RESP_ACK       = 8'h4B,
    parameter logic [7:0]  RESP_NAK       = 8'h3F,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_write_o,
    input  logic       tx_busy_i,
    output logic [7:0] addr_o,
    output logic [7:0] data_o,
    output logic       rd_o,
    output logic       wr_o,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       timeout_o
);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RESP} state_t;

    // Expiry fires on the edge at which the idle counter would reach TIMEOUT_CYCLES-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd2);

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [7:0]  resp_q, resp_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  tx_data_d, addr_d, data_d, resp_val;
    logic        tx_write_d, rd_d, wr_d, overrun_d, timeout_d, do_resp;

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        resp_d     = resp_q;
        tmo_d      = '0;
        tx_data_d  = tx_data_o;
        tx_write_d = 1'b0;
        addr_d     = addr_o;
        data_d     = data_o;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;
        do_resp    = 1'b0;
        resp_val   = resp_q;

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == CMD_WR) begin
                        op_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (rx_data_i == CMD_RD) begin
                        op_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        do_resp  = 1'b1;
                        resp_val = RESP_NAK;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = rx_data_i;
                    if (op_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        state_d = BUS_RD;
                        rd_d    = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            GET_DATA: begin
                if (rx_valid_i) begin
                    data_d  = rx_data_i;
                    state_d = BUS_WR;
                    wr_d    = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            BUS_WR: begin
                overrun_d = rx_valid_i;
                do_resp   = 1'b1;
                resp_val  = RESP_ACK;
            end
            BUS_RD: begin
                overrun_d = rx_valid_i;
                do_resp   = 1'b1;
                resp_val  = data_i;
            end
            RESP: begin
                overrun_d = rx_valid_i;
                do_resp   = 1'b1;
                resp_val  = resp_q;
            end
            default: state_d = IDLE;
        endcase

        // The response is pushed on the same edge it is produced when the transmitter
        // is free; RESP is only occupied while tx_busy_i holds it off.
        if (do_resp) begin
            if (!tx_busy_i) begin
                tx_data_d  = resp_val;
                tx_write_d = 1'b1;
                state_d    = IDLE;
            end else begin
                resp_d  = resp_val;
                state_d = RESP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            resp_q     <= '0;
            tmo_q      <= '0;
            tx_data_o  <= '0;
            tx_write_o <= 1'b0;
            addr_o     <= '0;
            data_o     <= '0;
            rd_o       <= 1'b0;
            wr_o       <= 1'b0;
            busy_o     <= 1'b0;
            overrun_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            resp_q     <= resp_d;
            tmo_q      <= tmo_d;
            tx_data_o  <= tx_data_d;
            tx_write_o <= tx_write_d;
            addr_o     <= addr_d;
            data_o     <= data_d;
            rd_o       <= rd_d;
            wr_o       <= wr_d;
            busy_o     <= (state_d != IDLE);
            overrun_o  <= overrun_d;
            timeout_o  <= timeout_d;
        end
    end

endmodule

// File: doc/pb_soc_cmd_bridge.md
Name: pb_soc_cmd_bridge

Overview:
Byte-stream command bridge and register-bus initiator for the Picoblaze SOC register file. It takes command bytes from a UART receive path, parses write and read commands, and drives single-cycle write/read transactions onto the 8-bit register bus. It returns one response byte per command to a UART transmit path. Its purpose is host/debug access to SOC registers without Picoblaze firmware involvement.

Parameters:
CMD_WR, 8'h57, command byte for a register write ('W'), followed by addr and data bytes
CMD_RD, 8'h52, command byte for a register read ('R'), followed by addr byte
RESP_ACK, 8'h4B, response byte after a completed write ('K')
RESP_NAK, 8'h3F, response byte for an unrecognised command byte ('?')
TIMEOUT_CYCLES, 50000, maximum idle clocks allowed between bytes of one command; legal range 2..65535

Ports:
clk_i  input  1  system clock; all logic rising-edge
rst_i  input  1  synchronous reset, active-low (0 = reset)
rx_data_i  input  8  received command byte
rx_valid_i  input  1  one-cycle strobe; rx_data_i valid
tx_data_o  output  8  response byte
tx_write_o  output  1  one-cycle strobe; push tx_data_o to transmitter
tx_busy_i  input  1  transmitter cannot accept a byte
addr_o  output  8  register bus address
data_o  output  8  register bus write data
rd_o  output  1  register bus read strobe
wr_o  output  1  register bus write strobe
data_i  input  8  register bus read data; combinational from the responder while rd_o=1
busy_o  output  1  1 whenever the FSM is not in IDLE
overrun_o  output  1  one-cycle pulse; a byte arrived while the bridge could not accept it
timeout_o  output  1  one-cycle pulse; a partial command was aborted

Behaviour:
- Reset (rst_i=0 at a rising edge): FSM goes to IDLE. All outputs are 0: tx_data_o, tx_write_o, addr_o, data_o, rd_o, wr_o, busy_o, overrun_o, timeout_o. The timeout counter is 0. Reset mid-command aborts the command with no bus cycle and no response.
- All outputs are registered.
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RESP.
- IDLE, on rx_valid_i:
  - byte==CMD_WR: op=write, go to GET_ADDR.
  - byte==CMD_RD: op=read, go to GET_ADDR.
  - any other byte: resp=RESP_NAK, go to RESP.
- GET_ADDR, on rx_valid_i: latch addr_o. If op=write, go to GET_DATA. If op=read, go to BUS_RD and set rd_o=1 at this same edge.
- GET_DATA, on rx_valid_i: latch data_o, go to BUS_WR, set wr_o=1 at this same edge.
- BUS_WR: lasts exactly one cycle with wr_o=1. addr_o and data_o are stable for that whole cycle. Next edge: wr_o=0, resp=RESP_ACK, go to RESP.
- BUS_RD: lasts exactly one cycle with rd_o=1. At the end of that cycle, capture data_i into resp. Next edge: rd_o=0, go to RESP.
- RESP: at any edge with tx_busy_i=0, set tx_data_o=resp and tx_write_o=1, go to IDLE. tx_write_o is high for exactly one cycle. If tx_busy_i=1, remain in RESP indefinitely; there is no timeout in RESP.
- addr_o and data_o hold their last values between commands.
- Latency:
  - Write: wr_o is high in the cycle after the data-byte strobe. tx_write_o is high 2 cycles after the data-byte strobe at the earliest.
  - Read: rd_o is high in the cycle after the addr-byte strobe. tx_write_o is high 2 cycles after the addr-byte strobe at the earliest.
  - NAK: tx_write_o is high 1 cycle after the command-byte strobe.
- Timeout:
  - A 16-bit counter clears on entry to GET_ADDR/GET_DATA and on every accepted byte, and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid_i: go to IDLE, pulse timeout_o, no bus cycle, no response.
  - A byte arriving on the same edge as expiry is accepted; the byte wins.
- Overrun: rx_valid_i while in BUS_WR, BUS_RD or RESP drops the byte and pulses overrun_o for one cycle. FSM behaviour is unchanged.
- rd_o and wr_o are never high together. Neither is ever asserted outside BUS_RD/BUS_WR.

Test Plan:
- Write: bytes 57,1B,A5 at 3-cycle spacing, tx_busy_i=0 -> one cycle with wr_o=1, addr_o=1B, data_o=A5; next cycle tx_write_o=1 with tx_data_o=4B; responder INT_MASK reads back A5.
- Read: bytes 52,1B after that write -> one cycle with rd_o=1, addr_o=1B; next cycle tx_write_o=1 with tx_data_o=A5; reading addr 10 (unmapped) returns 00.
- Bad command: byte 41 -> tx_data_o=3F with tx_write_o=1 one cycle later; no rd_o/wr_o; FSM back in IDLE and a following 52,0B read completes normally.
- Timeout: TIMEOUT_CYCLES=20; send 57,08 and then nothing -> timeout_o pulses at cycle 19 after the 08 strobe, no wr_o, busy_o=0; a byte strobed at cycle 18 instead is accepted as data.
- Backpressure/overrun: tx_busy_i=1 during a read -> FSM holds in RESP; an rx strobe meanwhile pulses overrun_o with no state change; releasing tx_busy_i gives tx_write_o in the following cycle.
- Reset: drive rst_i=0 for one cycle after 57,0C -> all outputs 0, FSM in IDLE; later 57,0C,FF writes correctly with no stale data.
